// File: rtl/ctrl_sequencer_pkg.sv
// ctrl_sequencer_pkg: shared op-codes, instruction classes and sequencer states
package ctrl_sequencer_pkg;
  localparam int BR_OFF_W = 7;
  localparam logic [8:0] FIN_ENC = 9'b000111000;
  localparam logic [8:0] RESET_ENC = 9'b000111001;
  typedef enum logic [3:0] {
    OP_PASS_VAL = 4'd0,
    OP_PASS_ACC = 4'd1,
    OP_ADD      = 4'd2,
    OP_SUB      = 4'd3,
    OP_AND      = 4'd4,
    OP_LSHFT    = 4'd5,
    OP_RSHFT    = 4'd6,
    OP_DIST     = 4'd7,
    OP_MIN      = 4'd8,
    OP_UNK      = 4'd15
  } alu_op_code_t;
  typedef enum logic [1:0] {CLS_ALU, CLS_BRANCH, CLS_FIN, CLS_RESET} cpu_op_class_t;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} seq_state_t;
endpackage

// File: rtl/ctrl_sequencer_instr_decode.sv
// instr_decode: combinational classification of a 9-bit instruction into class, ALU op and immediate
module instr_decode
  import ctrl_sequencer_pkg::*;
#(
  parameter int IMM_W = 6
) (
  input  logic [8:0]       instr,
  output cpu_op_class_t    op_class,
  output alu_op_code_t     alu_op,
  output logic [IMM_W-1:0] imm
);
  logic [2:0] grp;
  logic       sub;
  assign grp = instr[8:6];
  assign sub = instr[5];
  always_comb begin
    op_class = instr[8:7] == 2'b11 ? CLS_BRANCH :
               instr == FIN_ENC    ? CLS_FIN    :
               instr == RESET_ENC  ? CLS_RESET  : CLS_ALU;
    alu_op = grp == 3'b001 ? OP_ADD :
             grp == 3'b010 ? OP_SUB :
             grp == 3'b011 ? OP_AND :
             grp == 3'b100 ? (sub ? OP_RSHFT : OP_LSHFT) :
             grp == 3'b101 ? (sub ? OP_MIN : OP_DIST) :
             sub ? OP_PASS_ACC : OP_PASS_VAL;
    imm = IMM_W'((grp == 3'b001 || grp == 3'b010 || grp == 3'b011) ? instr[5:0] :
                 (grp == 3'b000 && sub) ? {3'b000, instr[2:0]} : {1'b0, instr[4:0]});
  end
endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: two-cycle fetch/exec sequencer driving ALU op-codes and the PC
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int IMM_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [8:0]       imem_data,
  input  logic             alu_zero,
  output logic [3:0]       alu_op,
  output logic [IMM_W-1:0] alu_imm,
  output logic             alu_valid,
  output logic             acc_clr,
  output logic             busy,
  output logic             done
);
  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d, pc_inc, pc_br;
  alu_op_code_t     alu_op_q, alu_op_d, dec_op;
  logic [IMM_W-1:0] alu_imm_q, alu_imm_d, dec_imm;
  logic             alu_valid_q, alu_valid_d, acc_clr_q, acc_clr_d;
  cpu_op_class_t    dec_class;
  instr_decode #(.IMM_W(IMM_W)) u_dec (
    .instr    (imem_data),
    .op_class (dec_class),
    .alu_op   (dec_op),
    .imm      (dec_imm)
  );
  assign pc_inc = pc_q + PC_W'(1);
  // signed offset is sign-extended to PC_W so the sum wraps naturally
  assign pc_br  = pc_q + PC_W'($signed(imem_data[BR_OFF_W-1:0]));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      alu_op_q    <= OP_UNK;
      alu_imm_q   <= '0;
      alu_valid_q <= 1'b0;
      acc_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      alu_op_q    <= alu_op_d;
      alu_imm_q   <= alu_imm_d;
      alu_valid_q <= alu_valid_d;
      acc_clr_q   <= acc_clr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (state_q == IDLE || state_q == DONE) begin
      if (start) begin
        state_d = FETCH;
        pc_d    = '0;
      end
    end else if (state_q == FETCH) begin
      state_d = EXEC;
    end else begin
      state_d = dec_class == CLS_FIN ? DONE : FETCH;
      pc_d    = dec_class == CLS_BRANCH ? (alu_zero ? pc_br : pc_inc) :
                dec_class == CLS_FIN    ? pc_q :
                dec_class == CLS_RESET  ? '0 : pc_inc;
    end
  end
  always_comb begin
    alu_valid_d = state_q == EXEC && dec_class == CLS_ALU;
    acc_clr_d   = state_q == EXEC && dec_class == CLS_RESET;
    alu_op_d    = alu_valid_d ? dec_op : alu_op_q;
    alu_imm_d   = alu_valid_d ? dec_imm : alu_imm_q;
  end
  assign imem_addr = pc_q;
  assign alu_op    = alu_op_q;
  assign alu_imm   = alu_imm_q;
  assign alu_valid = alu_valid_q;
  assign acc_clr   = acc_clr_q;
  assign busy      = state_q == FETCH || state_q == EXEC;
  assign done      = state_q == DONE;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: instruction-level reference model plus directed and random checks of ctrl_sequencer
module tb_ctrl_sequencer;
  import ctrl_sequencer_pkg::*;
  localparam int PCN = 256;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       alu_zero = 1'b0;
  logic [7:0] imem_addr;
  logic [8:0] imem_data;
  logic [3:0] alu_op;
  logic [5:0] alu_imm;
  logic       alu_valid, acc_clr, busy, done;
  logic [8:0] imem [PCN];
  logic [8:0]    d_in;
  cpu_op_class_t d_cls;
  alu_op_code_t  d_op;
  logic [5:0]    d_imm;
  int n_chk = 0;
  int n_fail = 0;
  int m_pc, m_op, m_imm;
  bit m_run, m_done, m_exec, m_valid, m_clr, m_opchk;

  ctrl_sequencer #(.PC_W(8), .IMM_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_zero(alu_zero), .alu_op(alu_op), .alu_imm(alu_imm), .alu_valid(alu_valid),
    .acc_clr(acc_clr), .busy(busy), .done(done)
  );
  instr_decode #(.IMM_W(6)) u_dec_tb (.instr(d_in), .op_class(d_cls), .alu_op(d_op), .imm(d_imm));

  always #5 clk = ~clk;
  always @(posedge clk) imem_data <= imem[imem_addr];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // kind: 0 alu, 1 branch, 2 fin, 3 reset-instruction
  function automatic void ref_dec(input int i, output int kind, output int op, output int imm);
    int top = i / 64;
    int b5 = (i / 32) % 2;
    kind = i >= 384 ? 1 : i == 56 ? 2 : i == 57 ? 3 : 0;
    op = -1;
    imm = 0;
    case (top)
      0: begin op = b5 ? int'(OP_PASS_ACC) : int'(OP_PASS_VAL); imm = b5 ? i % 8 : i % 32; end
      1: begin op = int'(OP_ADD); imm = i % 64; end
      2: begin op = int'(OP_SUB); imm = i % 64; end
      3: begin op = int'(OP_AND); imm = i % 64; end
      4: begin op = b5 ? int'(OP_RSHFT) : int'(OP_LSHFT); imm = i % 32; end
      5: begin op = b5 ? int'(OP_MIN) : int'(OP_DIST); imm = i % 32; end
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    int k, o, im, ins, off;
    if (reset) begin
      m_run = 0; m_done = 0; m_exec = 0; m_pc = 0;
      m_op = int'(OP_UNK); m_imm = 0; m_valid = 0; m_clr = 0; m_opchk = 1;
    end
    chk("m_imem_addr", imem_addr, m_pc);
    chk("m_busy", busy, m_run);
    chk("m_done", done, m_done);
    chk("m_alu_valid", alu_valid, m_valid);
    chk("m_acc_clr", acc_clr, m_clr);
    if (m_opchk) begin
      chk("m_alu_op", alu_op, m_op);
      chk("m_alu_imm", alu_imm, m_imm);
    end
    if (!reset) begin
      m_valid = 0; m_clr = 0; m_opchk = 0;
      if (!m_run) begin
        if (start) begin m_run = 1; m_done = 0; m_pc = 0; m_exec = 0; end
      end else if (!m_exec) begin
        m_exec = 1;
      end else begin
        m_exec = 0;
        ins = int'(imem[m_pc]);
        ref_dec(ins, k, o, im);
        if (k == 0) begin
          m_valid = 1; m_op = o; m_imm = im; m_opchk = 1; m_pc = (m_pc + 1) % PCN;
        end else if (k == 1) begin
          off = ins % 128;
          if (off >= 64) off -= 128;
          m_pc = alu_zero ? (m_pc + off + PCN) % PCN : (m_pc + 1) % PCN;
        end else if (k == 2) begin
          m_run = 0; m_done = 1;
        end else begin
          m_clr = 1; m_pc = 0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (!done && n < maxc) begin
      tick;
      n++;
    end
    chk("wait_done", done, 1);
  endtask

  function automatic logic [8:0] rand_instr();
    int r = $urandom_range(0, 15);
    logic [6:0] off = 7'($urandom_range(0, 8)) - 7'd4;
    return r == 0 ? FIN_ENC : r == 1 ? RESET_ENC : r < 5 ? {2'b11, off} : 9'($urandom_range(0, 383));
  endfunction

  initial begin
    int k, o, im;
    for (int a = 0; a < PCN; a++) imem[a] = FIN_ENC;
    for (int i = 0; i < 512; i++) begin
      d_in = 9'(i);
      #1;
      ref_dec(i, k, o, im);
      chk("dec_class", int'(d_cls), k);
      chk("dec_not_unk", int'(d_op != OP_UNK), 1);
      if (k == 0) begin
        chk("dec_op", int'(d_op), o);
        chk("dec_imm", int'(d_imm), im);
      end
    end
    tick; tick;
    start = 1'b1;
    tick;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_addr", imem_addr, 0);
    reset = 1'b0; start = 1'b0;
    tick;
    chk("rst_op_unk", alu_op, int'(OP_UNK));
    chk("rst_valid", alu_valid, 0);
    chk("rst_done", done, 0);
    imem[0] = 9'b001000101;
    imem[1] = FIN_ENC;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("add_fetch_addr", imem_addr, 0);
    chk("add_busy", busy, 1);
    tick; tick;
    chk("add_valid", alu_valid, 1);
    chk("add_op", alu_op, int'(OP_ADD));
    chk("add_imm", alu_imm, 5);
    chk("add_next_addr", imem_addr, 1);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("add_valid_single", alu_valid, 0);
    chk("start_busy_ignored", busy, 1);
    tick;
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_addr", imem_addr, 1);
    tick; tick;
    chk("fin_done_held", done, 1);
    for (int a = 0; a < 3; a++) imem[a] = 9'b000000001;
    imem[3] = 9'b110000010;
    imem[4] = FIN_ENC;
    imem[5] = FIN_ENC;
    for (int z = 1; z >= 0; z--) begin
      alu_zero = z[0];
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (8) tick;
      chk("br_next_addr", imem_addr, z ? 5 : 4);
      chk("br_no_valid", alu_valid, 0);
      wait_done(20);
    end
    imem[0] = 9'b111111111;
    imem[255] = FIN_ENC;
    alu_zero = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    chk("wrap_addr", imem_addr, 255);
    wait_done(10);
    imem[0] = 9'b000000011;
    imem[1] = RESET_ENC;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    chk("clr_pulse", acc_clr, 1);
    chk("clr_addr", imem_addr, 0);
    tick;
    reset = 1'b1;
    #1;
    chk("abort_valid", alu_valid, 0);
    chk("abort_addr", imem_addr, 0);
    chk("abort_op", alu_op, int'(OP_UNK));
    chk("abort_busy", busy, 0);
    tick;
    chk("abort_no_valid", alu_valid, 0);
    for (int ep = 0; ep < 8; ep++) begin
      reset = 1'b1;
      for (int a = 0; a < PCN; a++) imem[a] = rand_instr();
      tick;
      reset = 1'b0;
      for (int c = 0; c < 500; c++) begin
        start = $urandom_range(0, 15) == 0;
        alu_zero = 1'($urandom_range(0, 1));
        reset = $urandom_range(0, 299) == 0;
        tick;
      end
    end
    reset = 1'b0;
    start = 1'b0;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
